// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and default sizes for the stream accumulator
package acc_pkg;

   // Default operand/accumulator width and operand-count field width
   localparam int ACC_WIDTH_DEF = 4;
   localparam int ACC_CNT_W_DEF = 4;

   // Frame sequencing: wait for start, take operands, present the result
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/acc_adder.sv
// rtl/acc_adder.sv - WIDTH-bit ripple-carry adder built from full-adder cells, carry-in tied low
module acc_adder
   import acc_pkg::*;
#(
   parameter int WIDTH = ACC_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // carry[i] is the carry into bit i; the chain starts from a constant 0
   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   // One full-adder cell per bit, rippling the carry upward
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic half;
      assign half         = a[i] ^ b[i];
      assign sum[i]       = half ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & half);
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/stream_accumulator.sv
// rtl/stream_accumulator.sv - framed operand accumulator with sticky carry; SATURATE_EN selects saturating adds
module stream_accumulator
   import acc_pkg::*;
#(
   parameter int WIDTH = ACC_WIDTH_DEF,
   parameter int CNT_W = ACC_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_ops,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;

   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic [WIDTH-1:0] acc_next;
   logic             in_fire;

   // Single adder shared by every beat: running total plus incoming operand
   acc_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (acc_q),
      .b    (in_data),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Handshake decode straight from state so in_ready carries no extra cycle of latency
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_sum   = acc_q;
   assign out_carry = ovf_q;
   assign in_fire   = in_valid && in_ready;

`ifdef SATURATE_EN
   // Once any add in the frame has overflowed, the total is pinned at all-ones
   always_comb begin
      acc_next = add_sum;
      if (add_cout || ovf_q) begin
         acc_next = '1;
      end
   end
`else
   // Plain modulo arithmetic; the sticky flag records that a wrap happened
   always_comb begin
      acc_next = add_sum;
   end
`endif

   // Next-state and register-update decode for the frame sequencer
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      remaining_d = remaining_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               remaining_d = num_ops;
               acc_d       = '0;
               ovf_d       = 1'b0;
               state_d     = (num_ops == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            // A cycle without in_valid leaves the frame exactly where it was
            if (in_fire) begin
               acc_d       = acc_next;
               ovf_d       = ovf_q | add_cout;
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // Result is held until consumed; a coincident start is dropped
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any frame in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

// File: tb/tb_stream_accumulator.sv
// tb/tb_stream_accumulator.sv - directed vector bench for stream_accumulator (WIDTH=4, CNT_W=4)
module tb_stream_accumulator;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] num_ops;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_sum;
   logic       out_carry;
   logic       busy;

   int n_vec;
   int n_bad;

   stream_accumulator #(
      .WIDTH (4),
      .CNT_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_ops   (num_ops),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]        n;
      logic [15:0][3:0]  data;
      int                gap;
      logic [3:0]        exp_sum;
      logic              exp_carry;
   } frame_t;

   frame_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input frame_t f);
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 0);
      start   = 1'b1;
      num_ops = f.n;
      step();
      start = 1'b0;
      for (int i = 0; i < int'(f.n); i++) begin
         for (int g = 0; g < f.gap; g++) begin
            in_valid = 1'b0;
            check("gap_in_ready", in_ready, 1);
            check("gap_out_valid", out_valid, 0);
            step();
         end
         in_valid = 1'b1;
         in_data  = f.data[i];
         check("beat_in_ready", in_ready, 1);
         check("beat_out_valid", out_valid, 0);
         step();
      end
      in_valid = 1'b0;
      check("done_out_valid", out_valid, 1);
      check("done_in_ready", in_ready, 0);
      check("done_busy", busy, 1);
      check("done_sum", out_sum, f.exp_sum);
      check("done_carry", out_carry, f.exp_carry);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("post_out_valid", out_valid, 0);
      check("post_busy", busy, 0);
   endtask

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      start     = 1'b0;
      num_ops   = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      for (int k = 0; k < 6; k++) begin
         vecs[k].data = '0;
         vecs[k].gap  = 0;
      end
      // 3+4+5 = 12, no carry
      vecs[0].n = 4'd3; vecs[0].data[0] = 4'd3; vecs[0].data[1] = 4'd4; vecs[0].data[2] = 4'd5;
      vecs[0].exp_sum = 4'hC; vecs[0].exp_carry = 1'b0;
      // 9+8 = 17: wraps to 1, or saturates to F
      vecs[1].n = 4'd2; vecs[1].data[0] = 4'd9; vecs[1].data[1] = 4'd8;
`ifdef SATURATE_EN
      vecs[1].exp_sum = 4'hF;
`else
      vecs[1].exp_sum = 4'h1;
`endif
      vecs[1].exp_carry = 1'b1;
      // empty frame
      vecs[2].n = 4'd0; vecs[2].exp_sum = 4'h0; vecs[2].exp_carry = 1'b0;
      // 2+3 with 3 idle cycles before each beat
      vecs[3].n = 4'd2; vecs[3].data[0] = 4'd2; vecs[3].data[1] = 4'd3; vecs[3].gap = 3;
      vecs[3].exp_sum = 4'h5; vecs[3].exp_carry = 1'b0;
      // F+1 wraps to 0, then +0,+1: 1; saturating holds F
      vecs[4].n = 4'd4; vecs[4].data[0] = 4'hF; vecs[4].data[1] = 4'h1;
      vecs[4].data[2] = 4'h0; vecs[4].data[3] = 4'h1;
`ifdef SATURATE_EN
      vecs[4].exp_sum = 4'hF;
`else
      vecs[4].exp_sum = 4'h1;
`endif
      vecs[4].exp_carry = 1'b1;
      // longest frame: fifteen ones = 15, no carry
      vecs[5].n = 4'd15;
      for (int k = 0; k < 15; k++) vecs[5].data[k] = 4'd1;
      vecs[5].exp_sum = 4'hF; vecs[5].exp_carry = 1'b0;

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_sum", out_sum, 0);
      check("rst_carry", out_carry, 0);
      rst = 1'b0;
      step();

      for (int v = 0; v < 6; v++) begin
         run_frame(vecs[v]);
      end

      // Held result with back-pressure; start pulses during DONE are ignored
      start = 1'b1; num_ops = 4'd1; step();
      start = 1'b0;
      in_valid = 1'b1; in_data = 4'd7; step();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         start   = (c % 2 == 0);
         num_ops = 4'd3;
         check("hold_out_valid", out_valid, 1);
         check("hold_sum", out_sum, 4'h7);
         check("hold_in_ready", in_ready, 0);
         step();
      end
      // start coincident with the output handshake is dropped
      start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0; out_ready = 1'b0;
      check("drop_busy", busy, 0);
      check("drop_out_valid", out_valid, 0);
      step();
      check("drop_still_idle", busy, 0);

      // Asynchronous reset mid-frame
      start = 1'b1; num_ops = 4'd3; step();
      start = 1'b0;
      in_valid = 1'b1; in_data = 4'd5; step();
      in_valid = 1'b0;
      check("mid_sum", out_sum, 4'h5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_in_ready", in_ready, 0);
      check("arst_sum", out_sum, 0);
      check("arst_carry", out_carry, 0);
      check("arst_out_valid", out_valid, 0);
      step();
      rst = 1'b0;
      step();
      vecs[0].n = 4'd2; vecs[0].data[0] = 4'd1; vecs[0].data[1] = 4'd1; vecs[0].gap = 0;
      vecs[0].exp_sum = 4'h2; vecs[0].exp_carry = 1'b0;
      run_frame(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
